axi_wstream_gen: RTL and testbench

- Programmable AXI4 write-data beat generator. It sits directly upstream of the byte-counting monitor and drives the W-channel signals (wvalid, wstrb, wdata, wlast) that the monitor observes.
- Software or a testbench loads a byte count and a burst length, then pulses start.
- The block emits a deterministic incrementing-byte payload, honouring wready backpressure, and signals completion.

---
 rtl/axi_wstream_gen_pkg.sv | 25 ++
 rtl/axi_wstream_gen_beat.sv | 28 ++
 rtl/axi_wstream_gen.sv | 178 +++++++++++++++++
 tb/tb_axi_wstream_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wstream_gen_pkg.sv
// rtl/axi_wstream_gen_pkg.sv - shared types and helpers for the W-channel beat generator
package axi_wstream_gen_pkg;

  // Controller states; ST_GAP is only reachable when AXI_WSTREAM_GEN_THROTTLE_EN is defined
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Bytes per beat for a given W-channel data width
  function automatic int unsigned calc_bpb(input int unsigned data_width);
    return data_width / 8;
  endfunction

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_BPB    = calc_bpb(DEF_DATA_W);

  // Strobe bit k of a beat carrying nb valid bytes, filled from byte 0 upward
  function automatic logic strb_bit(input int unsigned k, input int unsigned nb);
    return k < nb;
  endfunction

endpackage

// File: rtl/axi_wstream_gen_beat.sv
// rtl/axi_wstream_gen_beat.sv - combinational incrementing-byte payload and strobe builder
module axi_wstream_gen_beat
  import axi_wstream_gen_pkg::*;
#(
  parameter int unsigned DW  = 128,
  parameter int unsigned NBW = 5
) (
  input  logic [NBW-1:0]  nb_i,
  input  logic [7:0]      off_i,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wstrb_o
);

  localparam int unsigned BPB = calc_bpb(DW);

  // Byte k carries (off+k) mod 256 when strobed; unstrobed lanes are zero
  always_comb begin
    wdata_o = '0;
    wstrb_o = '0;
    for (int k = 0; k < BPB; k++) begin
      if (strb_bit(k, 32'(nb_i))) begin
        wstrb_o[k]          = 1'b1;
        wdata_o[8*k +: 8]   = off_i + 8'(k);
      end
    end
  end

endmodule

// File: rtl/axi_wstream_gen.sv
// rtl/axi_wstream_gen.sv - AXI4 W-channel beat generator; optional inter-beat gaps via AXI_WSTREAM_GEN_THROTTLE_EN
module axi_wstream_gen
  import axi_wstream_gen_pkg::*;
#(
  parameter int unsigned p_axi_data_width = 128,
  parameter int unsigned cnt_width        = 32
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          start,
  input  logic [cnt_width-1:0]          total_bytes,
  input  logic [7:0]                    burst_len,
  input  logic [3:0]                    gap_cycles,
  output logic [p_axi_data_width-1:0]   p_axi_wdata,
  output logic [p_axi_data_width/8-1:0] p_axi_wstrb,
  output logic                          p_axi_wvalid,
  output logic                          p_axi_wlast,
  input  logic                          p_axi_wready,
  output logic                          busy,
  output logic                          done,
  output logic [cnt_width-1:0]          bytes_sent
);

  localparam int unsigned BPB = calc_bpb(p_axi_data_width);
  localparam int unsigned NBW = $clog2(BPB) + 1;
  localparam logic [cnt_width-1:0] BPB_C = cnt_width'(BPB);

  logic [1:0] rst_sync_q;
  logic       rst;

  state_e                        state_q, state_d;
  logic [cnt_width-1:0]          rem_q, rem_d;
  logic [cnt_width-1:0]          off_q, off_d;
  logic [cnt_width-1:0]          bytes_q, bytes_d;
  logic [7:0]                    blen_q, blen_d;
  logic [7:0]                    idx_q, idx_d;
  logic                          wvalid_q, wvalid_d;
  logic                          wlast_q, wlast_d;
  logic [p_axi_data_width-1:0]   wdata_q;
  logic [BPB-1:0]                wstrb_q;
  logic [NBW-1:0]                nb_cur, nb_nxt;
  logic [p_axi_data_width-1:0]   beat_wdata;
  logic [BPB-1:0]                beat_wstrb;

`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
  logic [3:0] gap_cnt_q, gap_cnt_d;
`else
  logic unused_gap;
  assign unused_gap = ^gap_cycles;
`endif

  // Reset asserts immediately and releases two clocks after arst falls
  always_ff @(posedge clk or posedge arst) begin
    if (arst) rst_sync_q <= 2'b11;
    else      rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // Bytes in the beat on the wire now, and in the beat being prepared for next cycle
  always_comb begin
    nb_cur = (rem_q < BPB_C) ? rem_q[NBW-1:0] : NBW'(BPB);
    nb_nxt = (rem_d < BPB_C) ? rem_d[NBW-1:0] : NBW'(BPB);
  end

  // Next-state, counters and beat bookkeeping
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    off_d   = off_q;
    bytes_d = bytes_q;
    blen_d  = blen_q;
    idx_d   = idx_q;
`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bytes_d = '0;
          off_d   = '0;
          idx_d   = '0;
          if (total_bytes != '0) begin
            state_d = ST_RUN;
            rem_d   = total_bytes;
            blen_d  = burst_len;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        if (wvalid_q && p_axi_wready) begin
          rem_d   = rem_q - cnt_width'(nb_cur);
          off_d   = off_q + cnt_width'(nb_cur);
          bytes_d = bytes_q + cnt_width'(nb_cur);
          idx_d   = wlast_q ? 8'd0 : idx_q + 8'd1;
          if (rem_q <= BPB_C) begin
            state_d = ST_FIN;
          end
`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
          else if (gap_cycles != 4'd0) begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_cycles;
          end
`endif
        end
      end
`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
      ST_GAP: begin
        if (gap_cnt_q <= 4'd1) state_d = ST_RUN;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat outputs are built from next-cycle state so they hold steady under backpressure
  always_comb begin
    wvalid_d = (state_d == ST_RUN);
    wlast_d  = wvalid_d && ((idx_d == blen_d) || (rem_d <= BPB_C));
  end

  axi_wstream_gen_beat #(
    .DW  (p_axi_data_width),
    .NBW (NBW)
  ) u_beat (
    .nb_i    (nb_nxt),
    .off_i   (off_d[7:0]),
    .wdata_o (beat_wdata),
    .wstrb_o (beat_wstrb)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      off_q    <= '0;
      bytes_q  <= '0;
      blen_q   <= '0;
      idx_q    <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      off_q    <= off_d;
      bytes_q  <= bytes_d;
      blen_q   <= blen_d;
      idx_q    <= idx_d;
      wvalid_q <= wvalid_d;
      wlast_q  <= wlast_d;
      wdata_q  <= wvalid_d ? beat_wdata : '0;
      wstrb_q  <= wvalid_d ? beat_wstrb : '0;
    end
  end

`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
  // Gap down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) gap_cnt_q <= 4'd0;
    else     gap_cnt_q <= gap_cnt_d;
  end
`endif

  assign p_axi_wdata  = wdata_q;
  assign p_axi_wstrb  = wstrb_q;
  assign p_axi_wvalid = wvalid_q;
  assign p_axi_wlast  = wlast_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);
  assign bytes_sent   = bytes_q;

endmodule

// File: tb/tb_axi_wstream_gen.sv
// tb/tb_axi_wstream_gen.sv - scoreboard bench for axi_wstream_gen
module tb_axi_wstream_gen;

  localparam int DW  = 128;
  localparam int CW  = 32;
  localparam int BPB = DW / 8;

  logic           clk = 1'b0;
  logic           arst;
  logic           start;
  logic [CW-1:0]  total_bytes;
  logic [7:0]     burst_len;
  logic [3:0]     gap_cycles;
  logic [DW-1:0]  wdata;
  logic [BPB-1:0] wstrb;
  logic           wvalid;
  logic           wlast;
  logic           wready;
  logic           busy;
  logic           done;
  logic [CW-1:0]  bytes_sent;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPB-1:0] strb;
    logic           last;
  } beat_t;

  beat_t sb_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  axi_wstream_gen #(
    .p_axi_data_width (DW),
    .cnt_width        (CW)
  ) dut (
    .clk          (clk),
    .arst         (arst),
    .start        (start),
    .total_bytes  (total_bytes),
    .burst_len    (burst_len),
    .gap_cycles   (gap_cycles),
    .p_axi_wdata  (wdata),
    .p_axi_wstrb  (wstrb),
    .p_axi_wvalid (wvalid),
    .p_axi_wlast  (wlast),
    .p_axi_wready (wready),
    .busy         (busy),
    .done         (done),
    .bytes_sent   (bytes_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference beats for one transfer
  function automatic void push_xfer(input int unsigned total, input int unsigned blen);
    int unsigned rem = total;
    int unsigned off = 0;
    int unsigned idx = 0;
    int unsigned nb;
    beat_t b;
    while (rem > 0) begin
      nb = (rem < BPB) ? rem : BPB;
      b  = '0;
      for (int k = 0; k < BPB; k++) begin
        if (k < nb) begin
          b.data[8*k +: 8] = 8'((off + k) & 255);
          b.strb[k]        = 1'b1;
        end
      end
      b.last = (idx == blen) || (rem <= BPB);
      sb_q.push_back(b);
      rem -= nb;
      off += nb;
      idx  = b.last ? 0 : idx + 1;
    end
  endfunction

  // Every accepted beat is popped and compared
  always @(negedge clk) begin : mon
    beat_t e;
    if (wvalid && wready) begin
      check("sb_nonempty", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wdata", wdata, e.data);
        check("wstrb", wstrb, e.strb);
        check("wlast", wlast, e.last);
      end
    end
  end

  task automatic start_xfer(input int unsigned total, input int unsigned blen, output int t0);
    push_xfer(total, blen);
    @(posedge clk); #1;
    start       = 1'b1;
    total_bytes = total;
    burst_len   = 8'(blen);
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input string tag, input int t0, input int exp_lat, input int exp_bytes);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, cyc - t0, exp_lat);
    check({tag, "_bytes"}, bytes_sent, exp_bytes);
    check({tag, "_busy_fin"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 1'b0);
    check({tag, "_busy_drop"}, busy, 1'b0);
    check({tag, "_wvalid_idle"}, wvalid, 1'b0);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [8:0] pat;
    arst        = 1'b1;
    start       = 1'b0;
    total_bytes = '0;
    burst_len   = '0;
    gap_cycles  = '0;
    wready      = 1'b0;
    #1;
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bytes", bytes_sent, 0);
    check("rst_wstrb", wstrb, 0);
    check("rst_wdata", wdata, 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    wready  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // Full beats, one 4-beat burst
    start_xfer(64, 3, t0);
    wait_done("t64", t0, 4, 64);

    // Partial final beat forces wlast mid-burst
    start_xfer(20, 7, t0);
    wait_done("t20", t0, 2, 20);

    // Backpressure on beat 2 for 5 cycles
    start_xfer(48, 15, t0);
    @(posedge clk); #1;
    wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wvalid", wvalid, 1'b1);
      check("stall_wdata", wdata, sb_q[0].data);
      check("stall_wstrb", wstrb, sb_q[0].strb);
      check("stall_wlast", wlast, sb_q[0].last);
    end
    @(posedge clk); #1;
    wready = 1'b1;
    wait_done("t48s", t0, 8, 48);

    // Zero-length transfer
    start_xfer(0, 0, t0);
    wait_done("t0", t0, 0, 0);

    // Start while busy is ignored
    start_xfer(32, 3, t0);
    start       = 1'b1;
    total_bytes = 200;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("tign", t0, 2, 32);

    // Two-beat bursts
    start_xfer(96, 1, t0);
    wait_done("t96", t0, 6, 96);

    // Reset in the middle of beat 3
    start_xfer(96, 1, t0);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_arst_wvalid", wvalid, 1'b1);
    check("pre_arst_bytes", bytes_sent, 32);
    arst = 1'b1;
    #1;
    check("arst_wvalid", wvalid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_bytes", bytes_sent, 0);
    check("arst_wlast", wlast, 1'b0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    repeat (4) @(posedge clk);
    start_xfer(32, 3, t0);
    wait_done("t_after_rst", t0, 2, 32);

    // Gap request: honoured only in the throttled build
    gap_cycles = 4'd3;
    start_xfer(48, 15, t0);
    pat = '0;
`ifdef AXI_WSTREAM_GEN_THROTTLE_EN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pat = {pat[7:0], wvalid};
    end
    check("gap_pattern", pat, 9'b100010001);
    wait_done("tgap", t0, 9, 48);
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat = {pat[7:0], wvalid};
    end
    check("nogap_pattern", pat, 9'b000000111);
    wait_done("tnogap", t0, 3, 48);
`endif
    gap_cycles = 4'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
